// File: rtl/in_shift_ctrl_pkg.sv
// Shared types, constants and helpers for the input shift register sequencer.
package in_shift_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PRESENT = 2'd2,
    SHIFT   = 2'd3
  } isc_state_t;

  localparam int OVR_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (v == {OVR_W{1'b1}}) ? v : v + OVR_W'(1);
  endfunction

endpackage

// File: rtl/in_shift_ctrl_if.sv
// Upstream column stream, shift register controls and lane presentation bus.
// OverrunCnt exists only when INSHIFT_CTRL_OVERRUN_EN is defined.
interface in_shift_ctrl_if #(parameter int N2 = 7);
  import in_shift_pkg::*;

  localparam int LW = idx_w(N2);

  logic          Start;
  logic          Abort;
  logic          AutoRestart;
  logic          InValid;
  logic          InReady;
  logic          SelShift;
  logic          SelKeep;
  logic          FrameValid;
  logic          LaneAck;
  logic [LW-1:0] LaneIdx;
  logic          Busy;
`ifdef INSHIFT_CTRL_OVERRUN_EN
  logic [OVR_W-1:0] OverrunCnt;

  modport master (
    input  Start, Abort, AutoRestart, InValid, LaneAck,
    output InReady, SelShift, SelKeep, FrameValid, LaneIdx, Busy, OverrunCnt
  );
  modport slave (
    output Start, Abort, AutoRestart, InValid, LaneAck,
    input  InReady, SelShift, SelKeep, FrameValid, LaneIdx, Busy, OverrunCnt
  );
`else
  modport master (
    input  Start, Abort, AutoRestart, InValid, LaneAck,
    output InReady, SelShift, SelKeep, FrameValid, LaneIdx, Busy
  );
  modport slave (
    output Start, Abort, AutoRestart, InValid, LaneAck,
    input  InReady, SelShift, SelKeep, FrameValid, LaneIdx, Busy
  );
`endif

endinterface

// File: rtl/in_shift_ctrl.sv
// Sequencer for the N2-lane x N1-bit input shift register: column capture, then lane-by-lane hand-off.
// Optional INSHIFT_CTRL_OVERRUN_EN adds a saturating OverrunCnt of columns offered while not loading.
module in_shift_ctrl
  import in_shift_pkg::*;
#(
  parameter int N1 = 200,
  parameter int N2 = 7
)
(
  input  logic            Clock,
  input  logic            nReset,
  in_shift_ctrl_if.master bus
);

  localparam int LW = idx_w(N2);
  localparam int CW = $clog2(N1 + 1);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_LOAD    = LOAD;
  localparam logic [1:0] ST_PRESENT = PRESENT;
  localparam logic [1:0] ST_SHIFT   = SHIFT;

  localparam logic [CW-1:0] LAST_COL  = CW'(N1 - 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(N2 - 1);

  logic [1:0]    state_r,    state_nxt_s;
  logic [CW-1:0] col_cnt_r,  col_cnt_nxt_s;
  logic [LW-1:0] lane_idx_r, lane_idx_nxt_s;

  logic in_ready_s, sel_shift_s, sel_keep_s, frame_valid_s, busy_s;

  // Next-state logic; Abort overrides every transition.
  always_comb begin
    state_nxt_s    = state_r;
    col_cnt_nxt_s  = col_cnt_r;
    lane_idx_nxt_s = lane_idx_r;
    if (bus.Abort) begin
      state_nxt_s    = ST_IDLE;
      col_cnt_nxt_s  = '0;
      lane_idx_nxt_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.Start) begin
            state_nxt_s   = ST_LOAD;
            col_cnt_nxt_s = '0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (bus.InValid) begin
            col_cnt_nxt_s = col_cnt_r + CW'(1);
            if (col_cnt_r == LAST_COL) begin
              state_nxt_s    = ST_PRESENT;
              lane_idx_nxt_s = '0;
            end else begin
              state_nxt_s = ST_LOAD;
            end
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end
        ST_PRESENT: begin
          if (bus.LaneAck) begin
            if (lane_idx_r == LAST_LANE) begin
              state_nxt_s    = bus.AutoRestart ? ST_LOAD : ST_IDLE;
              col_cnt_nxt_s  = '0;
              lane_idx_nxt_s = '0;
            end else begin
              state_nxt_s = ST_SHIFT;
            end
          end else begin
            state_nxt_s = ST_PRESENT;
          end
        end
        ST_SHIFT: begin
          state_nxt_s    = ST_PRESENT;
          lane_idx_nxt_s = lane_idx_r + LW'(1);
        end
        default: begin
          state_nxt_s    = ST_IDLE;
          col_cnt_nxt_s  = '0;
          lane_idx_nxt_s = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_r    <= ST_IDLE;
      col_cnt_r  <= '0;
      lane_idx_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      col_cnt_r  <= col_cnt_nxt_s;
      lane_idx_r <= lane_idx_nxt_s;
    end
  end

  // Output decode: in LOAD the register captures on the same edge the column is accepted.
  always_comb begin
    in_ready_s    = 1'b0;
    sel_shift_s   = 1'b0;
    sel_keep_s    = 1'b1;
    frame_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        sel_keep_s = 1'b1;
      end
      ST_LOAD: begin
        in_ready_s = 1'b1;
        sel_keep_s = !bus.InValid;
      end
      ST_PRESENT: begin
        frame_valid_s = 1'b1;
        sel_keep_s    = 1'b1;
      end
      ST_SHIFT: begin
        sel_shift_s = 1'b1;
        sel_keep_s  = 1'b0;
      end
      default: begin
        sel_keep_s = 1'b1;
      end
    endcase
  end

  assign busy_s         = (state_r != ST_IDLE);
  assign bus.InReady    = in_ready_s;
  assign bus.SelShift   = sel_shift_s;
  assign bus.SelKeep    = sel_keep_s;
  assign bus.FrameValid = frame_valid_s;
  assign bus.LaneIdx    = lane_idx_r;
  assign bus.Busy       = busy_s;

`ifdef INSHIFT_CTRL_OVERRUN_EN
  logic [OVR_W-1:0] ovr_cnt_r;

  // Columns offered by the framer while a frame is in progress but not loading.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ovr_cnt_r <= '0;
    end else if ((state_r == ST_IDLE) && bus.Start && !bus.Abort) begin
      ovr_cnt_r <= '0;
    end else if (bus.InValid && !in_ready_s && busy_s) begin
      ovr_cnt_r <= sat_inc(ovr_cnt_r);
    end else begin
      ovr_cnt_r <= ovr_cnt_r;
    end
  end

  assign bus.OverrunCnt = ovr_cnt_r;
`endif

endmodule

// File: tb/tb_in_shift_ctrl.sv
// Bench for in_shift_ctrl with a behavioural N2 x N1 shift register; lane data checked against captured columns.
module tb_in_shift_ctrl;

  localparam int N1 = 8;
  localparam int N2 = 3;

  logic          Clock;
  logic          nReset;
  logic [N2-1:0] shift_in;
  logic [N1-1:0] lanes [N2];

  int n_assert = 0;
  int n_fail   = 0;
  logic [N2-1:0] cols[$];

  in_shift_ctrl_if #(.N2(N2)) bus ();

  in_shift_ctrl #(.N1(N1), .N2(N2)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus.master)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Shift register driven by the controller: capture into LSB, or rotate lanes towards lane 0.
  always @(posedge Clock) begin
    if (bus.SelShift) begin
      for (int k = 0; k < N2 - 1; k++) lanes[k] <= lanes[k+1];
      lanes[N2-1] <= lanes[0];
    end else if (!bus.SelKeep) begin
      for (int k = 0; k < N2; k++) lanes[k] <= {lanes[k][N1-2:0], shift_in[k]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane i holds bit i of every captured column, oldest column in the MSB.
  function automatic logic [N1-1:0] exp_lane(input int i);
    logic [N1-1:0] r;
    logic [N2-1:0] c;
    r = '0;
    for (int j = 0; j < N1; j++) begin
      c = cols[j];
      r[N1-1-j] = c[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // mode 0: back-to-back counting columns; 1: InValid every other cycle; 2: random valid, data and Start noise.
  task automatic load_frame(input bit do_start, input int mode);
    int taken;
    int cyc;
    logic iv;
    logic [N2-1:0] c;
    cols.delete();
    if (do_start) begin
      tick();
      bus.Start = 1'b1; bus.InValid = 1'b0; bus.LaneAck = 1'b0;
      #1;
      check("start_idle_busy", bus.Busy, 32'd0);
    end
    taken = 0;
    cyc   = 0;
    while (taken < N1) begin
      tick();
      bus.Start   = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.LaneAck = 1'b0;
      iv = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      c  = (mode == 0) ? N2'(taken + 1) : N2'($urandom);
      bus.InValid = iv;
      shift_in    = c;
      #1;
      check("load_ready", bus.InReady, 32'd1);
      check("load_keep", bus.SelKeep, {31'd0, !iv});
      check("load_shift", bus.SelShift, 32'd0);
      check("load_fv", bus.FrameValid, 32'd0);
      if (iv) begin
        cols.push_back(c);
        taken++;
      end
      cyc++;
    end
    tick();
    bus.Start = 1'b0; bus.InValid = 1'b0;
    #1;
    check("frame_fv", bus.FrameValid, 32'd1);
    check("frame_idx", bus.LaneIdx, 32'd0);
    check("frame_ready", bus.InReady, 32'd0);
    check("frame_keep", bus.SelKeep, 32'd1);
    check("frame_lane0", lanes[0], exp_lane(0));
  endtask

  task automatic drain(input bit ar, input bit rnd);
    int w;
    bus.AutoRestart = ar;
    for (int i = 0; i < N2; i++) begin
      w = rnd ? $urandom_range(0, 2) : 0;
      repeat (w) begin
        tick();
        #1;
        check("wait_fv", bus.FrameValid, 32'd1);
        check("wait_idx", bus.LaneIdx, i);
        check("wait_lane", lanes[0], exp_lane(i));
      end
      bus.LaneAck = 1'b1;
      tick();
      bus.LaneAck = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (i < N2 - 1) begin
        check("shift_sel", bus.SelShift, 32'd1);
        check("shift_keep", bus.SelKeep, 32'd0);
        check("shift_fv", bus.FrameValid, 32'd0);
        tick();
        bus.LaneAck = 1'b0;
        #1;
        check("next_fv", bus.FrameValid, 32'd1);
        check("next_idx", bus.LaneIdx, i + 1);
        check("next_shift", bus.SelShift, 32'd0);
        check("next_lane", lanes[0], exp_lane(i + 1));
      end else if (ar) begin
        bus.LaneAck = 1'b0;
        check("restart_ready", bus.InReady, 32'd1);
        check("restart_busy", bus.Busy, 32'd1);
        check("restart_fv", bus.FrameValid, 32'd0);
      end else begin
        bus.LaneAck = 1'b0;
        check("done_busy", bus.Busy, 32'd0);
        check("done_ready", bus.InReady, 32'd0);
        check("done_keep", bus.SelKeep, 32'd1);
        check("done_fv", bus.FrameValid, 32'd0);
      end
    end
    bus.AutoRestart = 1'b0;
  endtask

  initial begin
    nReset = 1'b0;
    bus.Start = 1'b0; bus.Abort = 1'b0; bus.AutoRestart = 1'b0;
    bus.InValid = 1'b0; bus.LaneAck = 1'b0; shift_in = '0;
    repeat (3) @(negedge Clock);
    nReset = 1'b1;

    repeat (20) begin
      tick();
      check("rst_keep", bus.SelKeep, 32'd1);
      check("rst_shift", bus.SelShift, 32'd0);
      check("rst_ready", bus.InReady, 32'd0);
      check("rst_fv", bus.FrameValid, 32'd0);
      check("rst_busy", bus.Busy, 32'd0);
    end
    check("rst_idx", bus.LaneIdx, 32'd0);
`ifdef INSHIFT_CTRL_OVERRUN_EN
    check("rst_ovr", bus.OverrunCnt, 32'd0);
`endif

    load_frame(1'b1, 0);
    drain(1'b0, 1'b0);

    load_frame(1'b1, 1);
    drain(1'b1, 1'b0);
    load_frame(1'b0, 2);
    drain(1'b0, 1'b1);

    // Abort after five columns, then a fresh frame needs all N1 columns.
    tick();
    bus.Start = 1'b1; bus.InValid = 1'b0;
    repeat (5) begin
      tick();
      bus.Start = 1'b0; bus.InValid = 1'b1; shift_in = N2'($urandom);
      #1;
      check("abort_load_ready", bus.InReady, 32'd1);
    end
    tick();
    bus.InValid = 1'b0; bus.Abort = 1'b1;
    #1;
    check("abort_pre_ready", bus.InReady, 32'd1);
    tick();
    bus.Abort = 1'b0;
    #1;
    check("abort_busy", bus.Busy, 32'd0);
    check("abort_ready", bus.InReady, 32'd0);
    load_frame(1'b1, 0);
    drain(1'b0, 1'b1);

    // Abort while shifting clears the lane index.
    load_frame(1'b1, 2);
    bus.LaneAck = 1'b1;
    tick();
    bus.LaneAck = 1'b0; bus.Abort = 1'b1;
    #1;
    check("abshift_sel", bus.SelShift, 32'd1);
    tick();
    bus.Abort = 1'b0;
    #1;
    check("abshift_busy", bus.Busy, 32'd0);
    check("abshift_idx", bus.LaneIdx, 32'd0);
    check("abshift_keep", bus.SelKeep, 32'd1);

    // Asynchronous reset mid-frame.
    tick();
    bus.Start = 1'b1;
    repeat (3) begin
      tick();
      bus.Start = 1'b0; bus.InValid = 1'b1; shift_in = N2'($urandom);
    end
    #2;
    nReset = 1'b0;
    #1;
    check("arst_busy", bus.Busy, 32'd0);
    check("arst_ready", bus.InReady, 32'd0);
    check("arst_keep", bus.SelKeep, 32'd1);
    bus.InValid = 1'b0;
    tick();
    nReset = 1'b1;
    tick();
    check("arst_idle", bus.Busy, 32'd0);
    load_frame(1'b1, 0);
    drain(1'b0, 1'b0);

`ifdef INSHIFT_CTRL_OVERRUN_EN
    load_frame(1'b1, 0);
    bus.InValid = 1'b1;
    repeat (9) begin
      tick();
      check("ovr_fv", bus.FrameValid, 32'd1);
    end
    tick();
    bus.InValid = 1'b0; bus.Abort = 1'b1;
    #1;
    check("ovr_cnt10", bus.OverrunCnt, 32'd10);
    tick();
    bus.Abort = 1'b0;
    #1;
    check("ovr_hold", bus.OverrunCnt, 32'd10);
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    #1;
    check("ovr_clear", bus.OverrunCnt, 32'd0);
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
`endif

    repeat (4) begin
      load_frame(1'b1, 2);
      drain(1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
